pwm_audio_out: RTL and testbench

Parametrised multi-channel audio PWM output stage, successor to the fixed 8-bit volume/PWM pair driving aud_pwm. It accepts one signed sample per channel per valid pulse and double-buffers it so level changes occur only at PWM period boundaries. Per channel it applies a volume shift with soft-mute attenuation ramping, converts to offset binary and generates PWM. It sits between the FIR/ANC output path and the board's open-drain audio pins.

---
 rtl/audio_out_pkg.sv | 25 ++
 rtl/pwm_level_scaler.sv | 52 +++++
 rtl/pwm_audio_out.sv | 123 ++++++++++++
 tb/tb_pwm_audio_out.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_out_pkg.sv
// audio_out_pkg: shared types and level arithmetic for the PWM audio output stage
//   state_t    : soft-mute state
//   midscale   : PWM level that produces 50% duty (silence)
//   calc_level : signed sample -> offset-binary PWM level after volume/attenuation shift
package audio_out_pkg;

   typedef enum logic [1:0] {MUTED, RAMP_UP, PLAY, RAMP_DOWN} state_t;

   function automatic logic [31:0] midscale(input int pwm_w);
      return 32'd1 << (pwm_w - 1);
   endfunction

   // sample arrives sign-extended to 32 bits so the top-PWM_W slice can be taken by a plain shift
   function automatic logic [31:0] calc_level(input logic signed [31:0] sample, input int vol,
                                              input int att, input int sample_w, input int pwm_w,
                                              input int vol_w);
      int                 tot;
      logic signed [31:0] scaled;
      tot = (2 ** vol_w - 1) - vol + att;
      if (tot > sample_w - 1) tot = sample_w - 1;
      scaled = sample >>> tot;
      return ((32'(scaled) >> (sample_w - pwm_w)) & (midscale(pwm_w) * 2 - 1)) ^ midscale(pwm_w);
   endfunction

endpackage

// File: rtl/pwm_level_scaler.sv
// pwm_level_scaler: one channel's sample holding register, active PWM level and compare flop
//   clk_in, rst_n_in : clock, async active-low reset
//   i_load           : capture i_sample into the holding register
//   i_sample         : signed input sample
//   i_wrap           : last cycle of the PWM period; active level reloads on this edge
//   i_muted          : force midscale level
//   i_vol, i_att     : volume and soft-mute attenuation
//   i_count          : shared PWM counter
//   o_pwm            : registered PWM output
module pwm_level_scaler
   import audio_out_pkg::*;
#(
   parameter int SAMPLE_W = 16,
   parameter int PWM_W    = 8,
   parameter int VOL_W    = 3,
   parameter int ATT_W    = 4
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic                i_load,
   input  logic [SAMPLE_W-1:0] i_sample,
   input  logic                i_wrap,
   input  logic                i_muted,
   input  logic [VOL_W-1:0]    i_vol,
   input  logic [ATT_W-1:0]    i_att,
   input  logic [PWM_W-1:0]    i_count,
   output logic                o_pwm
);

   logic [SAMPLE_W-1:0] r_hold;
   logic [PWM_W-1:0]    r_lvl;
   logic [PWM_W-1:0]    w_lvl;
   logic                r_pwm;

   assign w_lvl = i_muted ? PWM_W'(midscale(PWM_W))
                          : PWM_W'(calc_level(32'(signed'(r_hold)), int'(i_vol), int'(i_att),
                                              SAMPLE_W, PWM_W, VOL_W));
   assign o_pwm = r_pwm;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_hold <= '0;
         r_lvl  <= PWM_W'(midscale(PWM_W));
         r_pwm  <= 1'b0;
      end else begin
         if (i_load) r_hold <= i_sample;
         if (i_wrap) r_lvl <= w_lvl;
         r_pwm <= i_count < r_lvl;
      end
   end

endmodule

// File: rtl/pwm_audio_out.sv
// pwm_audio_out: multi-channel PWM audio output with volume, soft-mute ramping and overrun detect
//   clk_in, rst_n_in  : clock, async active-low reset
//   sample_valid_in   : one-cycle strobe for samples_in (ch0 in LSBs)
//   vol_in            : volume, all-ones = unity gain
//   mute_in           : level-sensitive soft-mute request
//   clear_overrun_in  : clears overrun_out
//   pwm_out           : registered PWM per channel
//   period_start_out  : high while the counter is 0
//   mute_done_out     : high in the MUTED state
//   overrun_out       : sticky, more than one sample accepted in one PWM period
module pwm_audio_out
   import audio_out_pkg::*;
#(
   parameter int NUM_CH       = 2,
   parameter int SAMPLE_W     = 16,
   parameter int PWM_W        = 8,
   parameter int VOL_W        = 3,
   parameter int RAMP_PERIODS = 4
) (
   input  logic                       clk_in,
   input  logic                       rst_n_in,
   input  logic                       sample_valid_in,
   input  logic [NUM_CH*SAMPLE_W-1:0] samples_in,
   input  logic [VOL_W-1:0]           vol_in,
   input  logic                       mute_in,
   input  logic                       clear_overrun_in,
   output logic [NUM_CH-1:0]          pwm_out,
   output logic                       period_start_out,
   output logic                       mute_done_out,
   output logic                       overrun_out
);

   localparam int ATT_W = $clog2(SAMPLE_W);
   localparam int RC_W  = RAMP_PERIODS > 1 ? $clog2(RAMP_PERIODS) : 1;
   localparam logic [ATT_W-1:0] ATT_MAX = ATT_W'(SAMPLE_W - 1);

   logic [PWM_W-1:0] r_count;
   state_t           r_state, w_state_nx;
   logic [ATT_W-1:0] r_att, w_att_nx;
   logic [RC_W-1:0]  r_ramp, w_ramp_nx;
   logic             r_acc, r_ovr, r_ps;
   logic             w_wrap, w_step, w_muted;

   assign w_wrap           = &r_count;
   assign w_step           = r_ramp == RC_W'(RAMP_PERIODS - 1);
   assign w_muted          = r_state == MUTED;
   assign mute_done_out    = w_muted;
   assign overrun_out      = r_ovr;
   assign period_start_out = r_ps;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_count <= '0;
         r_state <= MUTED;
         r_att   <= ATT_MAX;
         r_ramp  <= '0;
         r_acc   <= 1'b0;
         r_ovr   <= 1'b0;
         r_ps    <= 1'b0;
      end else begin
         r_count <= r_count + 1'b1;
         r_state <= w_state_nx;
         r_att   <= w_att_nx;
         r_ramp  <= w_ramp_nx;
         r_ps    <= w_wrap;
         // a valid in the wrap cycle belongs to the next period's window
         r_acc   <= w_wrap ? sample_valid_in : r_acc | sample_valid_in;
         r_ovr   <= (sample_valid_in & r_acc & ~w_wrap) | (r_ovr & ~clear_overrun_in);
      end
   end

   // attenuation reaching its bound changes state on the same wrap as the final step
   always_comb begin
      w_state_nx = r_state;
      w_att_nx   = r_att;
      w_ramp_nx  = r_ramp;
      if (w_wrap) begin
         w_ramp_nx = w_step ? '0 : r_ramp + 1'b1;
         case (r_state)
            MUTED: if (!mute_in) w_state_nx = RAMP_UP;
            RAMP_UP: begin
               if (mute_in) w_state_nx = RAMP_DOWN;
               else if (r_att == '0) w_state_nx = PLAY;
               else if (w_step) begin
                  w_att_nx = r_att - 1'b1;
                  if (r_att == ATT_W'(1)) w_state_nx = PLAY;
               end
            end
            PLAY: if (mute_in) w_state_nx = RAMP_DOWN;
            RAMP_DOWN: begin
               if (!mute_in) w_state_nx = RAMP_UP;
               else if (r_att == ATT_MAX) w_state_nx = MUTED;
               else if (w_step) begin
                  w_att_nx = r_att + 1'b1;
                  if (r_att == ATT_MAX - 1'b1) w_state_nx = MUTED;
               end
            end
         endcase
         if (w_state_nx != r_state) w_ramp_nx = '0;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      pwm_level_scaler #(
         .SAMPLE_W(SAMPLE_W),
         .PWM_W   (PWM_W),
         .VOL_W   (VOL_W),
         .ATT_W   (ATT_W)
      ) u_scaler (
         .clk_in  (clk_in),
         .rst_n_in(rst_n_in),
         .i_load  (sample_valid_in),
         .i_sample(samples_in[c*SAMPLE_W +: SAMPLE_W]),
         .i_wrap  (w_wrap),
         .i_muted (w_muted),
         .i_vol   (vol_in),
         .i_att   (r_att),
         .i_count (r_count),
         .o_pwm   (pwm_out[c])
      );
   end

endmodule

// File: tb/tb_pwm_audio_out.sv
// tb_pwm_audio_out: self-checking bench for pwm_audio_out with a period-level reference model
module tb_pwm_audio_out;

   localparam int NCH = 2;
   localparam int SW  = 16;
   localparam int PW  = 8;
   localparam int VW  = 3;
   localparam int RP  = 2;
   localparam int PER = 2 ** PW;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              valid = 1'b0;
   logic              mute = 1'b1;
   logic              clr = 1'b0;
   logic [NCH*SW-1:0] samples = '0;
   logic [VW-1:0]     vol = 3'd7;
   logic [NCH-1:0]    pwm;
   logic              ps, mdone, ovr;

   always #5 clk = ~clk;

   pwm_audio_out #(
      .NUM_CH(NCH), .SAMPLE_W(SW), .PWM_W(PW), .VOL_W(VW), .RAMP_PERIODS(RP)
   ) dut (
      .clk_in          (clk),
      .rst_n_in        (rst_n),
      .sample_valid_in (valid),
      .samples_in      (samples),
      .vol_in          (vol),
      .mute_in         (mute),
      .clear_overrun_in(clr),
      .pwm_out         (pwm),
      .period_start_out(ps),
      .mute_done_out   (mdone),
      .overrun_out     (ovr)
   );

   int checks = 0;
   int errors = 0;

   // reference model: attenuation walks toward a goal; "settled" at 15 means muted
   int m_cnt, m_att, m_goal, m_ramp;
   bit m_settled, m_acc, m_ovr, ps_bad;
   int m_hold[NCH];
   int m_lvl[NCH];
   int hi[NCH];
   int last_hi[NCH];

   typedef struct {
      logic [15:0] s0;
      logic [15:0] s1;
      logic [2:0]  v;
      int          e0;
      int          e1;
   } vec_t;
   vec_t tab[6];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int ref_level(input int s, input int v, input int att);
      int tot = (2 ** VW - 1) - v + att;
      if (tot > SW - 1) tot = SW - 1;
      return (((s >>> tot) >>> (SW - PW)) + PER / 2) % PER;
   endfunction

   function automatic bit m_muted();
      return m_settled && m_att == SW - 1;
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_att = SW - 1; m_goal = SW - 1; m_ramp = 0;
      m_settled = 1; m_acc = 0; m_ovr = 0; ps_bad = 0;
      for (int c = 0; c < NCH; c++) begin
         m_hold[c] = 0; m_lvl[c] = PER / 2; hi[c] = 0; last_hi[c] = 0;
      end
   endtask

   task automatic model_edge();
      bit wrap = m_cnt == PER - 1;
      int tgt = mute ? SW - 1 : 0;
      if (wrap) begin
         for (int c = 0; c < NCH; c++)
            m_lvl[c] = m_muted() ? PER / 2 : ref_level(m_hold[c], int'(vol), m_att);
         if (m_settled) begin
            if (m_att != tgt) begin m_settled = 0; m_goal = tgt; m_ramp = 0; end
         end else if (m_goal != tgt) begin
            m_goal = tgt; m_ramp = 0;
         end else if (m_att == m_goal) begin
            m_settled = 1;
         end else begin
            m_ramp++;
            if (m_ramp == RP) begin
               m_ramp = 0;
               m_att += (m_goal > m_att) ? 1 : -1;
               if (m_att == m_goal) m_settled = 1;
            end
         end
      end
      if (valid && m_acc && !wrap) m_ovr = 1;
      else if (clr) m_ovr = 0;
      m_acc = wrap ? valid : (m_acc || valid);
      if (valid)
         for (int c = 0; c < NCH; c++) m_hold[c] = $signed(samples[c*SW +: SW]);
      m_cnt = (m_cnt + 1) % PER;
   endtask

   task automatic step();
      int pre;
      int old[NCH];
      @(posedge clk);
      pre = m_cnt;
      old = m_lvl;
      model_edge();
      #1;
      for (int c = 0; c < NCH; c++) hi[c] += int'(pwm[c]);
      if (pre == PER - 1) begin
         for (int c = 0; c < NCH; c++) begin
            check($sformatf("duty_ch%0d", c), hi[c], old[c]);
            last_hi[c] = hi[c];
            hi[c] = 0;
         end
         check("period_start", {ps_bad, ps}, 1);
         ps_bad = 0;
         check("overrun", ovr, m_ovr);
         check("mute_done", mdone, m_muted());
      end else if (ps) ps_bad = 1;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic run_to_wrap();
      do step(); while (m_cnt != 0);
   endtask

   task automatic run_wraps(input int n);
      repeat (n) run_to_wrap();
   endtask

   task automatic run_to_cnt(input int k);
      while (m_cnt != k) step();
   endtask

   task automatic send(input logic [15:0] s0, input logic [15:0] s1);
      samples = {s1, s0};
      valid = 1'b1;
      step();
      valid = 1'b0;
   endtask

   initial begin
      tab[0] = '{16'h4000, 16'h8000, 3'd7, 192, 0};
      tab[1] = '{16'h4000, 16'h7FFF, 3'd5, 144, 159};
      tab[2] = '{16'h2000, 16'h7FFF, 3'd7, 160, 255};
      tab[3] = '{16'h0000, 16'hFFFF, 3'd7, 128, 127};
      tab[4] = '{16'hC000, 16'h0100, 3'd0, 127, 128};
      tab[5] = '{16'h8000, 16'h1234, 3'd6, 64, 137};
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_pwm", pwm, 0);
      check("rst_mute_done", mdone, 1);
      check("rst_overrun", ovr, 0);
      check("rst_period_start", ps, 0);
      rst_n = 1'b1;
      run_wraps(2);
      run_to_cnt(10);
      send(16'h1111, 16'h2222);
      run(3);
      send(16'h3333, 16'h4444);
      check("ovr_before_rst", ovr, 1);
      run_to_cnt(40);
      check("pwm_high_before_rst", pwm, 3);
      rst_n = 1'b0;
      #1;
      check("async_rst_pwm", pwm, 0);
      check("async_rst_ovr", ovr, 0);
      check("async_rst_mute_done", mdone, 1);
      model_reset();
      @(posedge clk);
      #1;
      check("in_rst_period_start", ps, 0);
      rst_n = 1'b1;
      run_wraps(2);
      mute = 1'b0;
      vol = 3'd7;
      send(16'h4000, 16'h0000);
      run_wraps(34);
      check("play_level_ch0", last_hi[0], 192);
      check("play_mute_done", mdone, 0);
      foreach (tab[i]) begin
         vol = tab[i].v;
         send(tab[i].s0, tab[i].s1);
         run_wraps(2);
         check($sformatf("tab%0d_ch0", i), last_hi[0], tab[i].e0);
         check($sformatf("tab%0d_ch1", i), last_hi[1], tab[i].e1);
      end
      vol = 3'd7;
      run_to_cnt(10);
      send(16'h1000, 16'h0000);
      run(5);
      check("single_valid_no_ovr", ovr, 0);
      send(16'h2000, 16'h0000);
      check("overrun_set", ovr, 1);
      run_wraps(2);
      check("newest_wins", last_hi[0], 160);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("overrun_clear", ovr, 0);
      send(16'h2000, 16'h0000);
      run(3);
      samples = {16'h0000, 16'h2000};
      valid = 1'b1;
      clr = 1'b1;
      step();
      valid = 1'b0;
      clr = 1'b0;
      check("set_beats_clear", ovr, 1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("overrun_clear2", ovr, 0);
      run_to_cnt(PER - 1);
      send(16'h6000, 16'h0000);
      check("wrap_valid_no_ovr", ovr, 0);
      run_to_wrap();
      check("wrap_valid_deferred", last_hi[0], 160);
      run_to_wrap();
      check("wrap_valid_applied", last_hi[0], 224);
      send(16'h4000, 16'h0000);
      run_wraps(2);
      run_to_cnt(100);
      vol = 3'd3;
      run(50);
      vol = 3'd5;
      run_to_wrap();
      check("vol_mid_period_keep", last_hi[0], 192);
      run_to_wrap();
      check("vol_next_period", last_hi[0], 144);
      mute = 1'b1;
      run_wraps(33);
      check("muted_done", mdone, 1);
      check("muted_ch0", last_hi[0], 128);
      check("muted_ch1", last_hi[1], 128);
      mute = 1'b0;
      run_wraps(33);
      check("replay_ch0", last_hi[0], 144);
      mute = 1'b1;
      for (int i = 0; i < 40 && m_att != 7; i++) run_to_wrap();
      check("partial_att", m_att, 7);
      mute = 1'b0;
      run_wraps(17);
      check("partial_play_done", mdone, 0);
      check("partial_play_ch0", last_hi[0], 144);
      for (int i = 0; i < 40 * PER; i++) begin
         valid = $urandom_range(0, 59) == 0;
         samples = $urandom;
         if ($urandom_range(0, 399) == 0) mute = ~mute;
         if ($urandom_range(0, 96) == 0) vol = VW'($urandom_range(0, 7));
         clr = $urandom_range(0, 49) == 0;
         step();
      end
      valid = 1'b0;
      clr = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
